// File: rtl/pipes_list.sv
// pipes_list: bounded, ordered list of pipe records {x, y} for the game CPU.
// Records are appended at the tail. An iteration pass presents each record in
// insertion order. The caller either returns a replacement value or asks for
// the record to be removed, and the pass compacts the survivors in place.
// Optional build macro: PIPES_LIST_OVERFLOW_FLAG_EN adds a sticky 'overflow'
// output that records any insert request that was dropped.
module pipes_list #(
    parameter int CAPACITY = 16,
    parameter int X_WIDTH  = 12,
    parameter int Y_WIDTH  = 11
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ce,
    output logic [4:0]                 count,
    input  logic                       insert_en,
    input  logic [X_WIDTH+Y_WIDTH-1:0] insert_data,
    input  logic                       iter_start,
    output logic                       iter_done,
    input  logic [X_WIDTH+Y_WIDTH-1:0] iter_in,
    output logic [X_WIDTH+Y_WIDTH-1:0] iter_out,
    input  logic                       iter_remove
`ifdef PIPES_LIST_OVERFLOW_FLAG_EN
    ,
    output logic                       overflow
`endif
);

    localparam int W  = X_WIDTH + Y_WIDTH;
    localparam int AW = (CAPACITY > 1) ? $clog2(CAPACITY) : 1;
    localparam logic [4:0] CAP_COUNT = 5'(CAPACITY);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] ITER = 1'b1;

    logic [0:0]    state_r;
    logic [4:0]    count_r;
    logic [AW-1:0] head_r;
    logic [AW-1:0] rd_r;
    logic [AW-1:0] wr_r;
    logic          done_r;
    logic [W-1:0]  last_out_r;
    logic [W-1:0]  mem_r [CAPACITY];

    logic [AW-1:0] rd_slot_s;
    logic [AW-1:0] wr_slot_s;
    logic [AW-1:0] tail_slot_s;
    logic [W-1:0]  presented_s;
    logic          full_s;
    logic          last_s;
    logic [4:0]    survivors_s;
    logic          insert_ok_s;
    logic          commit_s;
    logic          drop_s;
    logic          mem_we_s;
    logic [AW-1:0] mem_addr_s;
    logic [W-1:0]  mem_data_s;

    // Physical slot decode and the per-cycle decisions of the controller.
    always_comb begin
        rd_slot_s   = head_r + rd_r;
        wr_slot_s   = head_r + wr_r;
        tail_slot_s = head_r + count_r[AW-1:0];
        presented_s = mem_r[rd_slot_s];
        full_s      = (count_r == CAP_COUNT);
        last_s      = ((5'(rd_r) + 5'd1) == count_r);
        if (iter_remove) begin
            survivors_s = 5'(wr_r);
        end else begin
            survivors_s = 5'(wr_r) + 5'd1;
        end
        // iter_start takes priority over insert_en in IDLE; inserts are
        // never accepted while a pass is running.
        insert_ok_s = (state_r == IDLE) && insert_en && !iter_start && !full_s;
        commit_s    = (state_r == ITER) && !iter_start;
        drop_s      = insert_en && !insert_ok_s;
    end

    // Select the single memory write of this cycle: tail append or pass commit.
    always_comb begin
        mem_we_s   = 1'b0;
        mem_addr_s = tail_slot_s;
        mem_data_s = insert_data;
        if (insert_ok_s) begin
            mem_we_s   = 1'b1;
            mem_addr_s = tail_slot_s;
            mem_data_s = insert_data;
        end else if (commit_s && !iter_remove) begin
            mem_we_s   = 1'b1;
            mem_addr_s = wr_slot_s;
            mem_data_s = iter_in;
        end else begin
            mem_we_s   = 1'b0;
        end
    end

    // Record storage; contents are meaningful only below count, so no reset.
    always_ff @(posedge clk) begin
        if (ce && !rst && mem_we_s) begin
            mem_r[mem_addr_s] <= mem_data_s;
        end
    end

    // List controller: count, pass indices, done flag and held output value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            count_r    <= 5'd0;
            head_r     <= '0;
            rd_r       <= '0;
            wr_r       <= '0;
            done_r     <= 1'b1;
            last_out_r <= '0;
        end else if (ce) begin
            case (state_r)
                IDLE: begin
                    if (iter_start) begin
                        if (count_r != 5'd0) begin
                            state_r <= ITER;
                            rd_r    <= '0;
                            wr_r    <= '0;
                            done_r  <= 1'b0;
                        end
                    end else if (insert_ok_s) begin
                        count_r <= count_r + 5'd1;
                    end
                end
                ITER: begin
                    if (iter_start) begin
                        // Restart without committing the presented element.
                        rd_r <= '0;
                        wr_r <= '0;
                    end else begin
                        last_out_r <= presented_s;
                        rd_r       <= rd_r + {{(AW-1){1'b0}}, 1'b1};
                        if (!iter_remove) begin
                            wr_r <= wr_r + {{(AW-1){1'b0}}, 1'b1};
                        end
                        if (last_s) begin
                            // Survivors now occupy logical 0..wr-1.
                            count_r <= survivors_s;
                            done_r  <= 1'b1;
                            state_r <= IDLE;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    done_r  <= 1'b1;
                end
            endcase
        end
    end

`ifdef PIPES_LIST_OVERFLOW_FLAG_EN
    logic overflow_r;

    // Sticky record of any insert request that did not land in the list.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_r <= 1'b0;
        end else if (ce && drop_s) begin
            overflow_r <= 1'b1;
        end
    end

    assign overflow = overflow_r;
`else
    logic unused_drop_s;
    assign unused_drop_s = drop_s;
`endif

    assign count     = count_r;
    assign iter_done = done_r;
    // During a pass the presented element is shown straight from storage so it
    // is valid the cycle after iter_start; in IDLE the last one is held.
    assign iter_out  = (state_r == ITER) ? presented_s : last_out_r;

endmodule

// File: tb/tb_pipes_list.sv
// Self-checking bench for pipes_list: directed scenarios plus a randomized
// mix, all checked against a queue-based model of the ordered list.
module tb_pipes_list;

    localparam int W = 23;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ce = 1'b1;
    logic [4:0]   count;
    logic         insert_en = 1'b0;
    logic [W-1:0] insert_data = '0;
    logic         iter_start = 1'b0;
    logic         iter_done;
    logic [W-1:0] iter_in = '0;
    logic [W-1:0] iter_out;
    logic         iter_remove = 1'b0;
`ifdef PIPES_LIST_OVERFLOW_FLAG_EN
    logic         overflow;
`endif

    int           n_cmp = 0;
    int           n_bad = 0;
    bit           ovf_exp = 1'b0;
    logic [W-1:0] mq [$];

    pipes_list dut (
        .clk         (clk),
        .rst         (rst),
        .ce          (ce),
        .count       (count),
        .insert_en   (insert_en),
        .insert_data (insert_data),
        .iter_start  (iter_start),
        .iter_done   (iter_done),
        .iter_in     (iter_in),
        .iter_out    (iter_out),
        .iter_remove (iter_remove)
`ifdef PIPES_LIST_OVERFLOW_FLAG_EN
        ,
        .overflow    (overflow)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] rec(int x, int y);
        return {x[11:0], y[10:0]};
    endfunction

    // Scroll a record one pixel left.
    function automatic logic [W-1:0] dec_x(logic [W-1:0] r);
        logic [11:0] x;
        x = r[22:11] - 12'd1;
        return {x, r[10:0]};
    endfunction

    task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mq.delete();
        ovf_exp = 1'b0;
        check_eq("rst_count", count, 0);
        check_eq("rst_done", iter_done, 1);
        check_eq("rst_out", iter_out, 0);
    endtask

    task automatic do_insert(logic [W-1:0] d);
        insert_en   = 1'b1;
        insert_data = d;
        tick();
        insert_en = 1'b0;
        if (mq.size() < 16) mq.push_back(d);
        else ovf_exp = 1'b1;
        check_eq("ins_count", count, mq.size());
        check_eq("ins_done", iter_done, 1);
    endtask

    // mode 0: keep all, x-1; mode 1: remove first, x-1 others;
    // mode 2: random removes, random replacements, random stray inserts.
    task automatic do_pass(int mode, int gap_at, bit ins_at_start);
        logic [W-1:0] nq [$];
        logic [W-1:0] nv;
        bit           rm;
        int           n;
        iter_start  = 1'b1;
        insert_en   = ins_at_start;
        insert_data = W'($urandom);
        tick();
        iter_start = 1'b0;
        insert_en  = 1'b0;
        if (ins_at_start) ovf_exp = 1'b1;
        n = mq.size();
        if (n == 0) begin
            check_eq("empty_done", iter_done, 1);
            check_eq("empty_count", count, 0);
            return;
        end
        check_eq("pass_done_lo", iter_done, 0);
        for (int i = 0; i < n; i++) begin
            check_eq("present", iter_out, mq[i]);
            if (i == gap_at) begin
                ce        = 1'b0;
                insert_en = 1'b1;
                repeat (5) tick();
                insert_en = 1'b0;
                ce        = 1'b1;
                check_eq("gap_hold", iter_out, mq[i]);
                check_eq("gap_done", iter_done, 0);
                check_eq("gap_count", count, n);
            end
            rm = (mode == 1 && i == 0) || (mode == 2 && $urandom_range(0, 3) == 0);
            nv = (mode == 2) ? W'($urandom) : dec_x(mq[i]);
            iter_remove = rm;
            iter_in     = nv;
            insert_en   = (mode == 2) ? ($urandom_range(0, 1) == 1) : 1'b0;
            insert_data = W'($urandom);
            if (insert_en) ovf_exp = 1'b1;
            if (!rm) nq.push_back(nv);
            tick();
            iter_remove = 1'b0;
            insert_en   = 1'b0;
        end
        check_eq("pass_done_hi", iter_done, 1);
        check_eq("pass_count", count, nq.size());
        check_eq("pass_hold_out", iter_out, mq[n-1]);
        mq = nq;
    endtask

    initial begin
        // Reset and two-record scroll passes.
        do_reset();
        do_insert(rec(639, 100));
        do_insert(rec(500, 50));
        do_pass(0, -1, 1'b0);
        do_pass(0, -1, 1'b0);
        check_eq("scroll_x0", iter_out[22:11], 12'd499);

        // Remove the first of three records, then check the survivors.
        do_reset();
        do_insert(rec(-40, 1));
        do_insert(rec(10, 2));
        do_insert(rec(20, 3));
        do_pass(1, -1, 1'b0);
        check_eq("rm_count", count, 2);
        do_pass(0, -1, 1'b0);

        // ce low in IDLE blocks inserts; fill to capacity and overfill.
        do_reset();
        ce        = 1'b0;
        insert_en = 1'b1;
        repeat (2) tick();
        insert_en = 1'b0;
        ce        = 1'b1;
        check_eq("ce_idle_count", count, 0);
        for (int i = 0; i < 17; i++) do_insert(W'($urandom));
        check_eq("full_count", count, 16);
`ifdef PIPES_LIST_OVERFLOW_FLAG_EN
        check_eq("ovf_full", overflow, ovf_exp);
`endif
        do_pass(0, -1, 1'b0);
        do_pass(2, 7, 1'b0);

        // iter_start on an empty list.
        do_reset();
        do_pass(0, -1, 1'b0);
        check_eq("empty_out", iter_out, 0);

        // iter_start together with insert_en: the insert is dropped.
        do_insert(rec(100, 7));
        do_insert(rec(200, 8));
        do_insert(rec(300, 9));
        do_pass(0, -1, 1'b1);
`ifdef PIPES_LIST_OVERFLOW_FLAG_EN
        check_eq("ovf_collide", overflow, ovf_exp);
`endif

        // Restart mid-pass: the committed element keeps its new value.
        iter_start = 1'b1;
        tick();
        iter_start = 1'b0;
        check_eq("rs_first", iter_out, mq[0]);
        iter_in = dec_x(mq[0]);
        tick();
        mq[0] = dec_x(mq[0]);
        check_eq("rs_second", iter_out, mq[1]);
        do_pass(0, -1, 1'b0);

        // Reset in the middle of a pass.
        iter_start = 1'b1;
        tick();
        iter_start = 1'b0;
        iter_in = dec_x(mq[0]);
        tick();
        do_reset();
`ifdef PIPES_LIST_OVERFLOW_FLAG_EN
        check_eq("ovf_rst", overflow, 0);
`endif

        // Randomized mix of inserts and passes.
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 3))
                0, 1: begin
                    int b;
                    b = $urandom_range(1, 5);
                    for (int j = 0; j < b; j++) do_insert(W'($urandom));
                end
                2: do_pass(2, $urandom_range(0, 20), 1'b0);
                default: do_pass(0, -1, 1'b0);
            endcase
        end
`ifdef PIPES_LIST_OVERFLOW_FLAG_EN
        check_eq("ovf_final", overflow, ovf_exp);
`endif
        check_eq("final_count", count, mq.size());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipes_list.md
Name: pipes_list

Overview:
- Bounded ordered list of pipe records for the game CPU; each record holds a signed horizontal position x and a gap-top y.
- Supports append-at-tail insertion.
- Supports a read-modify-write iteration pass. Every element is presented in insertion order, and the caller returns a replacement value or a remove request for it.
- The pass compacts the list in place. The CPU uses it to scroll pipes, draw them, and drop pipes that have gone off-screen.

Parameters:
- CAPACITY, 16: maximum number of stored records; power of two, at most 16.
- X_WIDTH, 12: width of x, two's-complement signed.
- Y_WIDTH, 11: width of y, unsigned.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- ce  input  1  clock enable; when low all state holds
- count  output  5  number of stored records
- insert_en  input  1  append insert_data at the tail
- insert_data  input  X_WIDTH+Y_WIDTH  record {x[MSBs], y[LSBs]}
- iter_start  input  1  begin an iteration pass
- iter_done  output  1  pass finished / no element presented
- iter_in  input  X_WIDTH+Y_WIDTH  replacement value for the presented element
- iter_out  output  X_WIDTH+Y_WIDTH  presented element
- iter_remove  input  1  delete the presented element instead of writing iter_in

Behaviour:
- Clock and reset: synchronous active-high reset rst; clock clk.
- Reset values (rst has priority over ce):
  - count=0, iter_done=1, iter_out=0.
  - Iteration inactive; head, read and write indices = 0.
- Storage: circular buffer with a head pointer. Logical element i sits at mem[(head+i) mod CAPACITY]. All updates below occur only on cycles with ce=1.
- States: IDLE, ITER.
- IDLE:
  - insert_en=1 and count<CAPACITY: write at logical index count; count+1 visible the next cycle.
  - insert_en=1 and count==CAPACITY: insert ignored, count unchanged.
  - iter_start=1 with count>0: go to ITER with rd=0, wr=0, iter_done=0.
  - iter_start=1 with count==0: stay IDLE, iter_done stays 1.
  - iter_start and insert_en together: iter_start wins, insert dropped.
- ITER:
  - iter_out combinationally shows logical element rd, so it is valid the cycle after iter_start.
  - Each ce cycle commits the presented element:
    - iter_remove=0: write iter_in to logical slot wr, then wr+1.
    - iter_remove=1: nothing written; wr unchanged.
    - In both cases rd+1.
  - When the committed element was the last (rd==count-1):
    - count<=new wr; head unchanged (survivors compacted to logical 0..wr-1).
    - iter_done<=1, return to IDLE.
  - insert_en is ignored in ITER.
  - iter_start in ITER restarts the pass at rd=0 without committing the current element. Elements already committed keep their new values.
- iter_out in IDLE holds the last presented value; on reset it is 0.
- iter_done is a registered level. It is high the cycle after the final commit and stays high until the next accepted iter_start.
- ce=0: no commit, no insert, outputs frozen; the iteration resumes when ce returns high.
- A write to slot wr never overwrites an unread element, because wr<=rd always holds.

Optional Feature:
- Macro PIPES_LIST_OVERFLOW_FLAG_EN, when defined, adds output overflow (1 bit):
  - Sticky; set when insert_en is dropped (list full, ITER, or lost to iter_start).
  - Cleared only by rst.
- Without the macro the port does not exist and dropped inserts are silent.

Test Plan:
- Reset, then insert records x=639,y=100 and x=500,y=50 -> count=2, iter_done=1.
- Iterate with iter_in=iter_out with x-1, no removes -> iter_out shows 639 then 500 on consecutive cycles; after the pass iter_done=1, count=2, and a second pass shows 638 and 499.
- Insert 3 records (x=-40, 10, 20) and iterate removing the first -> count=2; the next pass presents x=10 then x=20.
- Insert 16 records, then a 17th -> count stays 16 and the 17th is absent. With PIPES_LIST_OVERFLOW_FLAG_EN, overflow=1.
- iter_start with count=0 -> iter_done stays 1, count 0, no state change.
- Hold ce=0 for 5 cycles mid-pass, and separately assert rst mid-pass -> the ce=0 pass resumes with identical results; the reset pass leaves count=0, iter_done=1, iter_out=0.
